// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and address-width helper for the register file
package regfile_pkg;
    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;
    function automatic int clog2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: post-reset sequencer that zeroes one entry per cycle, then raises ready
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr,
    output logic          o_ready
);
    state_e        r_state, w_state_nxt;
    logic [AW-1:0] r_ptr, w_ptr_nxt;
    // state and clear pointer; reset restarts the sweep from entry 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end
    // sweep entries while clearing; the write of the last entry hands over to READY
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        o_clr_we    = 1'b0;
        if (r_state == CLEAR) begin
            o_clr_we  = 1'b1;
            w_ptr_nxt = r_ptr + 1'b1;
            if (r_ptr == AW'(DEPTH - 1)) begin
                w_state_nxt = READY;
                w_ptr_nxt   = '0;
            end
        end
    end
    assign o_clr_addr = r_ptr;
    assign o_ready    = (r_state == READY);
endmodule

// File: rtl/regfile_param_clr.sv
// regfile_param_clr: multi-read register file with clear-after-reset, bypass and zero entry
module regfile_param_clr
    import regfile_pkg::*;
#(
    parameter int  WIDTH    = 16,
    parameter int  DEPTH    = 8,
    parameter int  NUM_RD   = 2,
    parameter int  READ_LAT = 0,
    parameter int  BYPASS   = 0,
    parameter int  ZERO_REG = 0,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write,
    input  logic [AW-1:0]           wrAddr,
    input  logic [WIDTH-1:0]        wrData,
    input  logic [NUM_RD*AW-1:0]    rdAddr,
    output logic [NUM_RD*WIDTH-1:0] rdData,
    output logic                    ready
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_clr_we, w_user_we, w_we;
    logic [AW-1:0]    w_clr_addr, w_waddr;
    logic [WIDTH-1:0] w_wdata;

    regfile_clr_seq #(.DEPTH(DEPTH), .AW(AW)) u_seq (
        .clk        (clk),
        .reset      (reset),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_ready    (ready)
    );

    assign w_user_we = ready && write && (32'(wrAddr) < DEPTH) && !(ZERO_REG != 0 && wrAddr == '0);
    assign w_we      = w_clr_we || w_user_we;
    assign w_waddr   = w_clr_we ? w_clr_addr : wrAddr;
    assign w_wdata   = w_clr_we ? '0 : wrData;

    // storage is not reset; the clear sequencer zeroes it instead
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]    w_ra;
        logic [WIDTH-1:0] w_val;
        assign w_ra  = rdAddr[k*AW +: AW];
        assign w_val = (!ready || 32'(w_ra) >= DEPTH || (ZERO_REG != 0 && w_ra == '0)) ? '0 :
                       (BYPASS != 0 && w_user_we && w_ra == wrAddr) ? wrData : r_mem[w_ra];
        if (READ_LAT != 0) begin : g_reg
            logic [WIDTH-1:0] r_q;
            // registered read port, cleared by reset
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_q <= '0;
                else r_q <= w_val;
            end
            assign rdData[k*WIDTH +: WIDTH] = r_q;
        end else begin : g_comb
            assign rdData[k*WIDTH +: WIDTH] = w_val;
        end
    end
endmodule

// File: tb/tb_regfile_param_clr.sv
// tb_regfile_param_clr: directed checks of clear, read/write, bypass, zero entry, range and reset
module tb_regfile_param_clr;
    logic        clk, reset, write;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [5:0]  rd_addr;
    logic [31:0] rd0, rd1, rd2;
    logic [63:0] rd3;
    logic        rdy0, rdy1, rdy2, rdy3;
    int          n_tests, n_fail;

    regfile_param_clr dut0 (.clk(clk), .reset(reset), .write(write), .wrAddr(wr_addr),
        .wrData(wr_data[15:0]), .rdAddr(rd_addr), .rdData(rd0), .ready(rdy0));
    regfile_param_clr #(.BYPASS(1), .ZERO_REG(1)) dut1 (.clk(clk), .reset(reset), .write(write),
        .wrAddr(wr_addr), .wrData(wr_data[15:0]), .rdAddr(rd_addr), .rdData(rd1), .ready(rdy1));
    regfile_param_clr #(.READ_LAT(1), .BYPASS(1)) dut2 (.clk(clk), .reset(reset), .write(write),
        .wrAddr(wr_addr), .wrData(wr_data[15:0]), .rdAddr(rd_addr), .rdData(rd2), .ready(rdy2));
    regfile_param_clr #(.DEPTH(5), .WIDTH(32)) dut3 (.clk(clk), .reset(reset), .write(write),
        .wrAddr(wr_addr), .wrData(wr_data), .rdAddr(rd_addr), .rdData(rd3), .ready(rdy3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int t0, t2, t3;
        t0 = 0; t2 = 0; t3 = 0;
        reset = 1'b1; write = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (2) step();
        n_tests++;
        if ({rdy0, rdy1, rdy2, rdy3} !== 4'b0000) begin
            $display("FAIL reset_ready: got %b want 0000", {rdy0, rdy1, rdy2, rdy3}); n_fail++;
        end
        n_tests++;
        if ({rd0, rd1, rd2, rd3} !== 160'd0) begin
            $display("FAIL reset_rddata: got %h %h %h %h want 0", rd0, rd1, rd2, rd3); n_fail++;
        end
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (rdy0 && t0 == 0) t0 = e;
            if (rdy2 && t2 == 0) t2 = e;
            if (rdy3 && t3 == 0) t3 = e;
        end
        n_tests++;
        if (t0 !== 8) begin $display("FAIL clear_len_d8: got %0d edges want 8", t0); n_fail++; end
        n_tests++;
        if (t2 !== 8) begin $display("FAIL clear_len_lat1: got %0d edges want 8", t2); n_fail++; end
        n_tests++;
        if (t3 !== 5) begin $display("FAIL clear_len_d5: got %0d edges want 5", t3); n_fail++; end
        for (int a = 0; a < 8; a++) begin
            rd_addr = {3'(7 - a), 3'(a)};
            #1;
            n_tests++;
            if (rd0 !== 32'd0) begin $display("FAIL cleared_read a=%0d: got %h want 0", a, rd0); n_fail++; end
        end
    endtask

    task automatic test_write_read();
        step();
        write = 1'b1; wr_addr = 3'd3; wr_data = 32'h0000A5A5; rd_addr = {3'd5, 3'd3};
        #1;
        n_tests++;
        if (rd0[15:0] !== 16'h0000) begin $display("FAIL nobypass_same_cycle: got %h want 0000", rd0[15:0]); n_fail++; end
        n_tests++;
        if (rd1[15:0] !== 16'hA5A5) begin $display("FAIL bypass_same_cycle: got %h want a5a5", rd1[15:0]); n_fail++; end
        step();
        write = 1'b0;
        #1;
        n_tests++;
        if (rd0 !== 32'h0000A5A5) begin $display("FAIL read_3_5: got %h want 0000a5a5", rd0); n_fail++; end
        n_tests++;
        if (rd2 !== 32'h0000A5A5) begin $display("FAIL lat1_read_3_5: got %h want 0000a5a5", rd2); n_fail++; end
        n_tests++;
        if (rd3 !== 64'h00000000_0000A5A5) begin $display("FAIL w32_read_3_5: got %h want 0000a5a5", rd3); n_fail++; end
    endtask

    task automatic test_bypass();
        step();
        write = 1'b1; wr_addr = 3'd6; wr_data = 32'h00001234; rd_addr = {3'd3, 3'd6};
        #1;
        n_tests++;
        if (rd1[15:0] !== 16'h1234) begin $display("FAIL bypass_6: got %h want 1234", rd1[15:0]); n_fail++; end
        n_tests++;
        if (rd0 !== 32'hA5A5_0000) begin $display("FAIL nobypass_6: got %h want a5a50000", rd0); n_fail++; end
        n_tests++;
        if (rd3[31:0] !== 32'd0) begin $display("FAIL w32_oor_6: got %h want 0", rd3[31:0]); n_fail++; end
        step();
        write = 1'b0;
        #1;
        n_tests++;
        if (rd0[15:0] !== 16'h1234) begin $display("FAIL stored_6: got %h want 1234", rd0[15:0]); n_fail++; end
        n_tests++;
        if (rd2[15:0] !== 16'h1234) begin $display("FAIL lat1_bypass_6: got %h want 1234", rd2[15:0]); n_fail++; end
    endtask

    task automatic test_zero_reg();
        step();
        write = 1'b1; wr_addr = 3'd0; wr_data = 32'h0000FFFF; rd_addr = {3'd0, 3'd0};
        #1;
        n_tests++;
        if (rd1 !== 32'd0) begin $display("FAIL zero_no_bypass: got %h want 0", rd1); n_fail++; end
        step();
        wr_addr = 3'd1; wr_data = 32'h00000101; rd_addr = {3'd1, 3'd0};
        #1;
        n_tests++;
        if (rd1 !== 32'h0101_0000) begin $display("FAIL zero_bypass_1: got %h want 01010000", rd1); n_fail++; end
        step();
        write = 1'b0;
        #1;
        n_tests++;
        if (rd1 !== 32'h0101_0000) begin $display("FAIL zero_entry0: got %h want 01010000", rd1); n_fail++; end
        n_tests++;
        if (rd0 !== 32'h0101_FFFF) begin $display("FAIL plain_entry0: got %h want 0101ffff", rd0); n_fail++; end
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp3 [8];
        exp3 = '{32'h0000FFFF, 32'h00000101, 32'd0, 32'h0000A5A5, 32'd0, 32'd0, 32'd0, 32'd0};
        step();
        write = 1'b1; wr_addr = 3'd7; wr_data = 32'hDEADBEEF;
        step();
        write = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd_addr = {3'(a), 3'(a)};
            #1;
            n_tests++;
            if (rd3 !== {exp3[a], exp3[a]}) begin
                $display("FAIL w32_entry a=%0d: got %h want %h", a, rd3, {exp3[a], exp3[a]}); n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        t0 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            write = 1'b1; wr_addr = 3'(i); wr_data = 32'h1000 + i;
        end
        step();
        write = 1'b0; rd_addr = {3'd2, 3'd7};
        #1;
        n_tests++;
        if (rd0 !== 32'h1002_1007) begin $display("FAIL fill_read: got %h want 10021007", rd0); n_fail++; end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({rdy0, rd0, rd2} !== 65'd0) begin $display("FAIL async_reset: got %b %h %h want 0", rdy0, rd0, rd2); n_fail++; end
        step();
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        #1;
        n_tests++;
        if (rdy0 !== 1'b0) begin $display("FAIL reassert_ready: got %b want 0", rdy0); n_fail++; end
        step();
        reset = 1'b0; write = 1'b1; wr_addr = 3'd0; wr_data = 32'h00000BAD;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 4) write = 1'b0;
            if (rdy0 && t0 == 0) t0 = e;
        end
        n_tests++;
        if (t0 !== 8) begin $display("FAIL reclear_len: got %0d edges want 8", t0); n_fail++; end
        for (int a = 0; a < 8; a++) begin
            rd_addr = {3'(a), 3'(a)};
            #1;
            n_tests++;
            if ({rd0, rd3} !== 96'd0) begin $display("FAIL reclear_read a=%0d: got %h %h want 0", a, rd0, rd3); n_fail++; end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_out_of_range();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
